// File: rtl/mem_pkg.sv
// Shared data-memory definitions: FSM encodings, op codes and the latched request payload.
package mem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned OP_W       = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // One bit per operation so a combined load+store is representable.
  localparam logic [OP_W-1:0] OP_READ  = 2'b01;
  localparam logic [OP_W-1:0] OP_WRITE = 2'b10;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide RAM: synchronous write port, read port sync (registered) or async by parameter.
module dmem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8,
  parameter bit          ASYNC_READ  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (ASYNC_READ) begin : g_async
      logic unused_ctrl;
      assign unused_ctrl = re ^ reset;
      assign rdata = mem[raddr];
    end else begin : g_sync
      // Same-edge write returns the old word.
      always_ff @(posedge clk) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
      end
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: stalls the core for WAIT_CYCLES per aligned access, commits on entry to RESP.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned AW          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              stall,
  output logic              misaligned_err
);

  localparam int unsigned CW        = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  req_t              req_q, req_d;

  logic              aligned, req, commit, commit_in;
  logic [AW-1:0]     in_idx, cur_idx;
  logic [OP_W-1:0]   cur_op;
  logic [DATA_W-1:0] cur_wdata;
  logic              we, re;
  logic [AW-1:0]     waddr, raddr;
  logic [DATA_W-1:0] wdata;
  logic              unused_addr;

  assign in_idx         = addr[AW+1:2];
  assign unused_addr    = ^addr[31:AW+2];
  assign aligned        = is_aligned(addr[1:0]);
  assign req            = (memread | memwrite) & aligned;
  assign misaligned_err = (memread | memwrite) & ~aligned;

  // State, countdown and request latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
    end
  end

  // Next state, stall and RAM port steering.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    req_d     = req_q;
    stall     = 1'b0;
    commit    = 1'b0;
    commit_in = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req && !ZERO_WAIT) begin
          stall       = 1'b1;
          idx_d       = in_idx;
          req_d.op    = {memwrite, memread};
          req_d.wdata = writedata;
          cnt_d       = CW'(WAIT_CYCLES - 1);
          if (WAIT_CYCLES == 1) begin
            state_d   = ST_RESP;
            commit    = 1'b1;
            commit_in = 1'b1;
          end else begin
            state_d   = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Single-wait commits straight from the inputs; longer waits use the latch.
    cur_idx   = commit_in ? in_idx : idx_q;
    cur_op    = commit_in ? {memwrite, memread} : req_q.op;
    cur_wdata = commit_in ? writedata : req_q.wdata;

    if (ZERO_WAIT) begin
      we    = memwrite & aligned & ~reset;
      re    = 1'b0;
      waddr = in_idx;
      raddr = in_idx;
      wdata = writedata;
    end else begin
      we    = commit & (|(cur_op & OP_WRITE)) & ~reset;
      re    = commit & (|(cur_op & OP_READ)) & ~reset;
      waddr = cur_idx;
      raddr = cur_idx;
      wdata = cur_wdata;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW),
    .ASYNC_READ (ZERO_WAIT)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .re   (re),
    .raddr(raddr),
    .rdata(readdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: three responders (2, 1 and 0 wait states) driven with directed accesses.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2, mr2, mw2, st2, me2;
  logic [31:0] ad2, wd2, rd2;
  logic        rst1, mr1, mw1, st1, me1;
  logic [31:0] ad1, wd1, rd1;
  logic        rst0, mr0, mw0, st0, me0;
  logic [31:0] ad0, wd0, rd0;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .AW(8)) dut2 (
    .clk(clk), .reset(rst2), .memread(mr2), .memwrite(mw2), .addr(ad2), .writedata(wd2),
    .readdata(rd2), .stall(st2), .misaligned_err(me2));
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1), .AW(8)) dut1 (
    .clk(clk), .reset(rst1), .memread(mr1), .memwrite(mw1), .addr(ad1), .writedata(wd1),
    .readdata(rd1), .stall(st1), .misaligned_err(me1));
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .AW(8)) dut0 (
    .clk(clk), .reset(rst0), .memread(mr0), .memwrite(mw0), .addr(ad0), .writedata(wd0),
    .readdata(rd0), .stall(st0), .misaligned_err(me0));

  int total = 0;
  int bad   = 0;
  logic [31:0] q2[$], q1[$], q0[$];
  int run2 = 0, run1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Response monitors: a falling stall marks the RESP cycle of a completed access.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst2) run2 = 0;
    else if (st2) run2++;
    else if (run2 != 0) begin
      if (q2.size() == 0) chk("w2_unexpected_resp", rd2, 32'hx);
      else begin
        e = q2.pop_front();
        chk("w2_readdata", rd2, e);
        chk("w2_stall_len", 32'(run2), 32'd2);
      end
      run2 = 0;
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst1) run1 = 0;
    else if (st1) run1++;
    else if (run1 != 0) begin
      if (q1.size() == 0) chk("w1_unexpected_resp", rd1, 32'hx);
      else begin
        e = q1.pop_front();
        chk("w1_readdata", rd1, e);
        chk("w1_stall_len", 32'(run1), 32'd1);
      end
      run1 = 0;
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst0 && (mr0 || mw0)) begin
      chk("w0_stall", 32'(st0), 32'd0);
      chk("w0_misaligned", 32'(me0), 32'd0);
      if (mr0) begin
        if (q0.size() == 0) chk("w0_unexpected_read", rd0, 32'hx);
        else begin
          e = q0.pop_front();
          chk("w0_readdata", rd0, e);
        end
      end
    end
  end

  // One access held until RESP, then dropped; ex is the readdata expected in RESP.
  task automatic acc(input int w, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] ex);
    bit done;
    @(posedge clk); #1;
    if (w == 2) begin mr2 = rd; mw2 = wr; ad2 = a; wd2 = d; q2.push_back(ex); end
    else        begin mr1 = rd; mw1 = wr; ad1 = a; wd1 = d; q1.push_back(ex); end
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!((w == 2) ? st2 : st1)) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL acc_timeout: w=%0d addr=%h still stalled after 20 cycles", w, a);
    end
    @(posedge clk); #1;
    if (w == 2) begin mr2 = 1'b0; mw2 = 1'b0; end
    else        begin mr1 = 1'b0; mw1 = 1'b0; end
  endtask

  initial begin
    {rst2, rst1, rst0} = 3'b111;
    {mr2, mw2, mr1, mw1, mr0, mw0} = '0;
    {ad2, wd2, ad1, wd1, ad0, wd0} = '0;
    repeat (2) @(posedge clk);
    #1 {rst2, rst1, rst0} = 3'b000;
    @(negedge clk);
    chk("rst_stall2", 32'(st2), 32'd0);
    chk("rst_rd2", rd2, 32'd0);
    chk("rst_err2", 32'(me2), 32'd0);
    chk("rst_stall1", 32'(st1), 32'd0);
    chk("rst_rd1", rd1, 32'd0);

    // Two wait states: store then load.
    acc(2, 0, 1, 32'h10, 32'hDEADBEEF, 32'h0);
    acc(2, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF);

    // Misaligned load and store: flagged, no stall, nothing touched.
    @(posedge clk); #1 mr2 = 1'b1; ad2 = 32'h13;
    @(negedge clk);
    chk("mis_err", 32'(me2), 32'd1);
    chk("mis_stall", 32'(st2), 32'd0);
    @(posedge clk); #1 mr2 = 1'b0; mw2 = 1'b1; ad2 = 32'h11; wd2 = 32'hBAD;
    @(negedge clk);
    chk("mis_err_wr", 32'(me2), 32'd1);
    chk("mis_stall_wr", 32'(st2), 32'd0);
    chk("mis_rd_hold", rd2, 32'hDEADBEEF);
    @(posedge clk); #1 mw2 = 1'b0;
    acc(2, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF);

    // Index wraps modulo depth; upper address bits ignored.
    acc(2, 0, 1, 32'h400, 32'hA5A5A5A5, 32'hDEADBEEF);
    acc(2, 1, 0, 32'h0, 32'h0, 32'hA5A5A5A5);

    // Combined load+store: old word returned, new word stored.
    acc(2, 0, 1, 32'h8, 32'h1, 32'hA5A5A5A5);
    acc(2, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF);
    acc(2, 1, 1, 32'h8, 32'h2, 32'h1);
    acc(2, 1, 0, 32'h8, 32'h0, 32'h2);

    // Reset during BUSY of a store aborts it.
    acc(2, 0, 1, 32'h20, 32'h77, 32'h2);
    @(posedge clk); #1 mw2 = 1'b1; ad2 = 32'h20; wd2 = 32'h55;
    @(posedge clk); #1 rst2 = 1'b1; mw2 = 1'b0;
    @(posedge clk); #1 rst2 = 1'b0;
    @(negedge clk);
    chk("abort_stall", 32'(st2), 32'd0);
    chk("abort_rd", rd2, 32'd0);
    acc(2, 1, 0, 32'h20, 32'h0, 32'h77);
    acc(2, 1, 0, 32'hFFFF_FC20, 32'h0, 32'h77);

    // One wait state.
    acc(1, 0, 1, 32'h0, 32'h12345678, 32'h0);
    acc(1, 1, 0, 32'h0, 32'h0, 32'h12345678);
    acc(1, 0, 1, 32'h4, 32'h9, 32'h12345678);
    acc(1, 1, 0, 32'h4, 32'h0, 32'h9);
    acc(1, 1, 0, 32'h0, 32'h0, 32'h12345678);

    // Zero wait: async read follows the address, store lands on the edge.
    @(posedge clk); #1 mw0 = 1'b1; ad0 = 32'h8; wd0 = 32'h1;
    @(posedge clk); #1 ad0 = 32'h10; wd0 = 32'h33;
    @(posedge clk); #1 mr0 = 1'b1; ad0 = 32'h8; wd0 = 32'h2; q0.push_back(32'h1);
    @(posedge clk); #1 mw0 = 1'b0; q0.push_back(32'h2);
    @(posedge clk); #1 ad0 = 32'h10; q0.push_back(32'h33);
    @(posedge clk); #1 mr0 = 1'b0;

    repeat (3) @(posedge clk);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
